// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage driving a req/gnt/rvalid data port with byte strobes.
// Illegal or misaligned ops are trapped to an error response without a memory request.
module load_store_unit #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] alu_res,
    input  logic [DWIDTH-1:0] store_data,
    input  logic [2:0]        funct3,
    input  logic              is_store,
    input  logic [4:0]        rd_in,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] sd_q, sd_d, data_q, data_d, lane, fmt, wdata;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              st_q, st_d, err_q, err_d, f3_ok, mis;
    logic [3:0]        we;

    assign f3_ok = is_store ? (funct3 <= 3'd2) : (funct3 != 3'd3 && funct3 <= 3'd5);
    assign mis   = (funct3[1:0] == 2'b01 && alu_res[0]) ||
                   (funct3[1:0] == 2'b10 && alu_res[1:0] != 2'b00);
    assign lane  = mem_rdata >> {addr_q[1:0], 3'b000};
    // funct3[2] set means unsigned, so the extension bit is forced to zero
    assign fmt   = f3_q[1:0] == 2'b00 ? {{(DWIDTH-8){~f3_q[2] & lane[7]}}, lane[7:0]} :
                   f3_q[1:0] == 2'b01 ? {{(DWIDTH-16){~f3_q[2] & lane[15]}}, lane[15:0]} : lane;
    assign we    = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                   f3_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign wdata = f3_q[1:0] == 2'b00 ? {4{sd_q[7:0]}} :
                   f3_q[1:0] == 2'b01 ? {2{sd_q[15:0]}} : sd_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sd_d    = sd_q;
        f3_d    = f3_q;
        st_d    = st_q;
        rd_d    = rd_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = alu_res;
                sd_d    = store_data;
                f3_d    = funct3;
                st_d    = is_store;
                rd_d    = rd_in;
                err_d   = !f3_ok || mis;
                data_d  = '0;
                state_d = err_d ? RESP : REQ;
            end
            REQ:  if (mem_gnt) state_d = st_q ? RESP : WAIT;
            WAIT: if (mem_rvalid) begin
                data_d  = fmt;
                state_d = RESP;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sd_q    <= '0;
            f3_q    <= '0;
            st_q    <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sd_q    <= sd_d;
            f3_q    <= f3_d;
            st_q    <= st_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign req_ready  = state_q == IDLE;
    assign mem_req    = state_q == REQ;
    assign mem_addr   = mem_req ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
    assign mem_we     = mem_req && st_q ? we : 4'b0000;
    assign mem_wdata  = mem_req && st_q ? wdata : '0;
    assign resp_valid = state_q == RESP;
    assign resp_data  = resp_valid ? data_q : '0;
    assign resp_rd    = resp_valid && !st_q && !err_q ? rd_q : '0;
    assign resp_err   = resp_valid && err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store/error/reset vectors against hand-computed results.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] alu_res = '0, store_data = '0;
    logic [2:0]  funct3 = '0;
    logic        is_store = 1'b0;
    logic [4:0]  rd_in = '0;
    logic        mem_req, mem_gnt = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int n_cmp = 0, n_err = 0;
    int o_lat;
    logic [31:0] o_data, o_wd, o_addr;
    logic [4:0]  o_rd;
    logic [3:0]  o_we;
    logic        o_err, o_req, o_unst, o_busy;

    always #5 clk = ~clk;

    load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .alu_res(alu_res), .store_data(store_data), .funct3(funct3), .is_store(is_store),
        .rd_in(rd_in), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one op, plays memory with gdly stall cycles before gnt, holds resp_ready low rdly cycles
    task automatic run_op(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                          input logic st, input logic [4:0] rd, input logic [31:0] rdata,
                          input int gdly, input int rdly);
        int cyc, rc;
        logic pend;
        @(negedge clk);
        alu_res = a; store_data = sd; funct3 = f3; is_store = st; rd_in = rd;
        mem_rdata = rdata; req_valid = 1'b1;
        o_req = 0; o_unst = 0; o_busy = 0; o_we = '0; o_wd = '0; o_addr = '0;
        rc = 0; pend = 0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 40) begin
            if (req_ready) o_busy = 1;
            mem_rvalid = pend;
            pend = 0;
            if (mem_req) begin
                if (!o_req) begin
                    o_addr = mem_addr; o_we = mem_we; o_wd = mem_wdata;
                end else if (mem_addr !== o_addr || mem_we !== o_we || mem_wdata !== o_wd)
                    o_unst = 1;
                o_req = 1;
                rc++;
                mem_gnt = rc > gdly;
                pend = mem_gnt && !st;
            end else mem_gnt = 1'b0;
            @(negedge clk);
            cyc++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        o_lat = cyc; o_data = resp_data; o_rd = resp_rd; o_err = resp_err;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== o_data || resp_rd !== o_rd || resp_err !== o_err)
                o_unst = 1;
            if (req_ready) o_busy = 1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_drop", resp_valid, 0);
        check("idle_ready", req_ready, 1);
    endtask

    initial begin
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_resp_data", resp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h1000, 0, 3'b010, 0, 5'd5, 32'hDEADBEEF, 0, 0);
        check("lw_lat", o_lat, 3);
        check("lw_addr", o_addr, 32'h1000);
        check("lw_we", o_we, 0);
        check("lw_data", o_data, 32'hDEADBEEF);
        check("lw_rd", o_rd, 5);
        check("lw_err", o_err, 0);

        run_op(32'h1003, 0, 3'b000, 0, 5'd7, 32'h80FF1234, 0, 0);
        check("lb_data", o_data, 32'hFFFFFF80);
        check("lb_addr", o_addr, 32'h1000);
        check("lb_rd", o_rd, 7);
        run_op(32'h1003, 0, 3'b100, 0, 5'd7, 32'h80FF1234, 0, 0);
        check("lbu_data", o_data, 32'h00000080);
        run_op(32'h1002, 0, 3'b101, 0, 5'd8, 32'h80FF1234, 0, 0);
        check("lhu_data", o_data, 32'h000080FF);
        run_op(32'h1000, 0, 3'b001, 0, 5'd8, 32'h80FF1234, 0, 0);
        check("lh_lo_data", o_data, 32'h00001234);

        run_op(32'h2001, 32'h000000AB, 3'b000, 1, 5'd9, 0, 0, 0);
        check("sb_lat", o_lat, 2);
        check("sb_we", o_we, 4'b0010);
        check("sb_wdata", o_wd, 32'hABABABAB);
        check("sb_addr", o_addr, 32'h2000);
        check("sb_rd", o_rd, 0);
        check("sb_data", o_data, 0);
        run_op(32'h2002, 32'h1234CDEF, 3'b001, 1, 5'd9, 0, 0, 0);
        check("sh_we", o_we, 4'b1100);
        check("sh_wdata", o_wd, 32'hCDEFCDEF);
        check("sh_rd", o_rd, 0);
        run_op(32'h3000, 32'h11223344, 3'b010, 1, 5'd1, 0, 0, 0);
        check("sw_we", o_we, 4'b1111);
        check("sw_wdata", o_wd, 32'h11223344);

        run_op(32'h1002, 0, 3'b010, 0, 5'd4, 32'hFFFFFFFF, 0, 0);
        check("mis_lat", o_lat, 1);
        check("mis_req", o_req, 0);
        check("mis_err", o_err, 1);
        check("mis_data", o_data, 0);
        check("mis_rd", o_rd, 0);
        run_op(32'h1000, 0, 3'b011, 0, 5'd4, 32'hFFFFFFFF, 0, 0);
        check("ill_lat", o_lat, 1);
        check("ill_req", o_req, 0);
        check("ill_err", o_err, 1);
        run_op(32'h2001, 32'h55, 3'b001, 1, 5'd4, 0, 0, 0);
        check("sh_mis_err", o_err, 1);
        check("sh_mis_req", o_req, 0);

        run_op(32'h1002, 0, 3'b001, 0, 5'd3, 32'h80FF1234, 5, 3);
        check("stall_lat", o_lat, 8);
        check("stall_data", o_data, 32'hFFFF80FF);
        check("stall_rd", o_rd, 3);
        check("stall_addr", o_addr, 32'h1000);
        check("stall_stable", o_unst, 0);
        check("stall_busy", o_busy, 0);

        @(negedge clk);
        alu_res = 32'h1000; funct3 = 3'b010; is_store = 0; rd_in = 5'd6;
        mem_rdata = 32'h12345678; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_op_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst_op_wait", resp_valid, 0);
        check("rst_op_busy", req_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_ready", req_ready, 1);
        check("rst_async_req", mem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stale_resp", resp_valid, 0);
        check("stale_ready", req_ready, 1);
        @(negedge clk);
        check("stale_resp2", resp_valid, 0);
        check("stale_data", resp_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage block directly downstream of the execute ALU in the RISC-V core. It takes the ALU result as the effective address for RV32I loads and stores. It then drives a request/grant/response data-memory port with byte-lane strobes, and returns sign- or zero-extended load data tagged with its destination register. Misaligned and illegal-width accesses are trapped without touching memory.

Parameters:
AWIDTH, 32, address width; the low 2 bits select the byte lane
DWIDTH, 32, data width; fixed at 32 (RV32I)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  execute stage presents a memory op
req_ready  output  1  unit can accept an op
alu_res  input  AWIDTH  effective address (rs1+imm from ALU)
store_data  input  DWIDTH  rs2 value
funct3  input  3  access width/sign (RV32I encoding)
is_store  input  1  1=store, 0=load
rd_in  input  5  load destination register
mem_req  output  1  memory request
mem_gnt  input  1  memory accepted request
mem_addr  output  AWIDTH  word-aligned address {alu_res[AWIDTH-1:2],2'b00}
mem_we  output  4  byte write strobes (0 for loads)
mem_wdata  output  DWIDTH  lane-replicated store data
mem_rvalid  input  1  read data valid
mem_rdata  input  DWIDTH  read word
resp_valid  output  1  op complete
resp_ready  input  1  writeback accepts response
resp_data  output  DWIDTH  formatted load data (0 for stores/errors)
resp_rd  output  5  destination (0 for stores/errors)
resp_err  output  1  misaligned or illegal funct3

Behaviour:
- Reset: rst_n is asynchronous and active-low. All outputs 0 except req_ready=1. State=IDLE; captured address/data/funct3/rd cleared.
- FSM states: IDLE, REQ, WAIT, RESP.
- req_ready=1 only in IDLE. An op is accepted on req_valid&&req_ready at a rising edge; alu_res, store_data, funct3, is_store and rd_in are registered then.
- Legality on accept:
  - Valid load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Valid store funct3 values: 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned op goes IDLE->RESP with resp_err=1, resp_data=0, resp_rd=0. mem_req is never asserted for it.
- Legal op: IDLE->REQ. In REQ, mem_req=1 and mem_addr/mem_we/mem_wdata are held stable until mem_gnt.
- On mem_gnt in REQ: a store goes to RESP; a load goes to WAIT.
- Memory guarantees mem_rvalid no earlier than the cycle after gnt. mem_rvalid is sampled only in WAIT and ignored in every other state.
- WAIT + mem_rvalid: capture the formatted load and go to RESP.
- RESP: resp_valid=1 and outputs are stable until resp_ready. RESP+resp_ready -> IDLE, with resp_valid low the next cycle.
- No back-to-back acceptance; each op takes at least 1 cycle in IDLE.
- Store strobes and data:
  - SB: mem_we = 4'b0001<<addr[1:0]; wdata = {4{sd[7:0]}}.
  - SH: mem_we = 4'b0011<<{addr[1],1'b0}; wdata = {2{sd[15:0]}}.
  - SW: mem_we = 4'b1111; wdata = sd.
- Load formatting: lane = mem_rdata >> (8*addr[1:0]). LB/LH sign-extend lane[7:0]/lane[15:0]. LBU/LHU zero-extend. LW passes the word.
- Latency with zero-wait memory (gnt in first REQ cycle, rvalid the next cycle), counted from the accept edge:
  - Load: resp_valid at cycle 3.
  - Store: resp_valid at cycle 2.
  - Error: resp_valid at cycle 1.
- Reset mid-operation returns to IDLE immediately. A memory response still outstanding at reset is dropped because rvalid is ignored outside WAIT.
- mem_gnt held low indefinitely keeps the unit in REQ; there is no timeout.

Test Plan:
- LW addr 0x1000, mem_rdata 0xDEADBEEF, gnt and rvalid immediate -> mem_addr 0x1000, mem_we 0; resp_data 0xDEADBEEF, resp_rd=rd_in, resp_valid at cycle 3.
- LB addr 0x1003 with rdata 0x80FF1234 -> resp_data 0xFFFFFF80; LBU same address -> 0x00000080; LHU addr 0x1002 -> 0x000080FF.
- SB addr 0x2001, store_data 0x000000AB -> mem_we 4'b0010, mem_wdata 0xABABABAB; SH addr 0x2002 -> mem_we 4'b1100; resp_rd 0.
- LW addr 0x1002, and a funct3=011 load -> no mem_req ever; resp_valid at cycle 1 with resp_err=1, resp_data 0.
- gnt delayed 5 cycles, then resp_ready held low 3 cycles -> mem_req and mem_addr stable throughout REQ; resp outputs stable while held; req_ready=0 until return to IDLE.
- rst_n pulsed low during WAIT, then stale mem_rvalid=1 arrives -> returns to IDLE, resp_valid stays 0, req_ready=1.
